// File: rtl/wave_capture_pkg.sv
// Shared constants and state encoding for the waveform capture block.
package wave_capture_pkg;

  localparam int DEFAULT_SAMPLE_WIDTH = 16;
  localparam int DEFAULT_FRAME_LEN    = 256;
  localparam int ADDR_BITS            = $clog2(DEFAULT_FRAME_LEN);
  localparam int OUT_WIDTH            = 8;

  // Quantisation keeps the sign bit (inverted to offset binary) plus the
  // next QUANT_MAG_BITS bits below it.
  localparam int QUANT_MAG_BITS = OUT_WIDTH - 1;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_t;

endpackage

// File: rtl/dffr.sv
// Generic register with synchronous active-high reset to zero.
module dffr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/wave_capture_trigger.sv
// Remembers the previous sample and flags a negative -> non-negative crossing.
module wave_trigger #(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
  output logic [SAMPLE_WIDTH-1:0] prev_sample,
  output logic                    trigger
);

  always_ff @(posedge clk) begin
    if (reset)                 prev_sample <= '0;
    else if (new_sample_ready) prev_sample <= new_sample_in;
  end

  // Zero counts as non-negative, so only the sign bits matter.
  assign trigger = new_sample_ready
                 & prev_sample[SAMPLE_WIDTH-1]
                 & ~new_sample_in[SAMPLE_WIDTH-1];

endmodule

// File: rtl/wave_capture.sv
// Captures one trigger-aligned frame into the idle half of a double-buffered RAM
// and swaps halves when the display reports it is safe to do so.
module wave_capture
  import wave_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int FRAME_LEN    = DEFAULT_FRAME_LEN
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           new_sample_ready,
  input  logic [SAMPLE_WIDTH-1:0]        new_sample_in,
  input  logic                           wave_display_idle,
  output logic [$clog2(FRAME_LEN):0]     write_address,
  output logic                           write_enable,
  output logic [OUT_WIDTH-1:0]           write_sample,
  output logic                           read_index
);

  localparam int AW = $clog2(FRAME_LEN);

  logic [1:0]              state_q;
  state_t                  state_d;
  logic [AW-1:0]           count_q, count_d;
  logic                    read_index_d;
  logic                    write_enable_d;
  logic [AW:0]             write_address_d;
  logic [OUT_WIDTH-1:0]    write_sample_d;
  logic [SAMPLE_WIDTH-1:0] prev_sample;
  logic                    trigger;
  logic                    do_write;
  logic [AW-1:0]           write_index;

  wave_trigger #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_trigger (
    .clk              (clk),
    .reset            (reset),
    .new_sample_ready (new_sample_ready),
    .new_sample_in    (new_sample_in),
    .prev_sample      (prev_sample),
    .trigger          (trigger)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_t'(state_q);
    count_d      = count_q;
    read_index_d = read_index;
    do_write     = 1'b0;
    write_index  = count_q;

    case (state_q)
      ARMED: begin
        if (trigger) begin
          do_write    = 1'b1;
          write_index = '0;
          count_d     = AW'(1);
          state_d     = ACTIVE;
        end
      end
      ACTIVE: begin
        if (new_sample_ready) begin
          do_write = 1'b1;
          count_d  = count_q + AW'(1);
          if (count_q == AW'(FRAME_LEN - 1)) state_d = WAIT;
        end
      end
      WAIT: begin
        // A strobe arriving with the idle flag is swallowed: no trigger check.
        if (wave_display_idle) begin
          read_index_d = ~read_index;
          state_d      = ARMED;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  assign write_enable_d  = do_write;
  assign write_address_d = do_write ? {~read_index, write_index} : write_address;
  assign write_sample_d  = do_write
                         ? {~new_sample_in[SAMPLE_WIDTH-1],
                            new_sample_in[SAMPLE_WIDTH-2 -: QUANT_MAG_BITS]}
                         : write_sample;

  dffr #(.WIDTH(2)) u_state (
    .clk(clk), .reset(reset), .d(state_d), .q(state_q)
  );

  dffr #(.WIDTH(AW)) u_count (
    .clk(clk), .reset(reset), .d(count_d), .q(count_q)
  );

  dffr #(.WIDTH(1)) u_read_index (
    .clk(clk), .reset(reset), .d(read_index_d), .q(read_index)
  );

  dffr #(.WIDTH(1)) u_write_enable (
    .clk(clk), .reset(reset), .d(write_enable_d), .q(write_enable)
  );

  dffr #(.WIDTH(AW + 1)) u_write_address (
    .clk(clk), .reset(reset), .d(write_address_d), .q(write_address)
  );

  dffr #(.WIDTH(OUT_WIDTH)) u_write_sample (
    .clk(clk), .reset(reset), .d(write_sample_d), .q(write_sample)
  );

endmodule
